// File: rtl/cache_cpu_front_if.sv
// cache_cpu_front_if
//   Groups the CPU request port, the cache_fsm handshake and the directory
//   lookup results of cache_cpu_front into one bundle.
//   slave  : view used by cache_cpu_front (consumes requests and updates,
//            produces sampled request and lookup results)
//   master : view used by the CPU / cache_fsm side
//   Signals:
//     cs, wr_rd, addr           CPU request (valid while cs high)
//     rdy, valid_set, dirty_set cache_fsm completion and directory updates
//     cs_sampled_dly            one-cycle pulse, request captured
//     wr_rd_cpu_q, addr_q       registered request
//     hit, line_dirty           lookup of addr_q in the directory
//     victim_tag                stored tag at the indexed line
//     busy                      request outstanding
interface cache_cpu_front_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned IDX_W  = 3,
   parameter int unsigned OFF_W  = 5
);
   localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W;

   logic              cs;
   logic              wr_rd;
   logic [ADDR_W-1:0] addr;
   logic              rdy;
   logic              valid_set;
   logic              dirty_set;
   logic              cs_sampled_dly;
   logic              wr_rd_cpu_q;
   logic [ADDR_W-1:0] addr_q;
   logic              hit;
   logic              line_dirty;
   logic [TAG_W-1:0]  victim_tag;
   logic              busy;

   modport slave (
      input  cs, wr_rd, addr, rdy, valid_set, dirty_set,
      output cs_sampled_dly, wr_rd_cpu_q, addr_q, hit, line_dirty, victim_tag, busy
   );

   modport master (
      output cs, wr_rd, addr, rdy, valid_set, dirty_set,
      input  cs_sampled_dly, wr_rd_cpu_q, addr_q, hit, line_dirty, victim_tag, busy
   );
endinterface

// File: rtl/cache_cpu_front.sv
// cache_cpu_front
//   CPU-side front end of the cache controller. Captures one CPU request at a
//   time, announces it to cache_fsm with a one-cycle cs_sampled_dly pulse,
//   looks the registered address up in a tag/valid/dirty directory and keeps
//   the request outstanding until cache_fsm returns rdy. Directory updates
//   (line fill, write) requested by cache_fsm are applied at the index of the
//   current request.
//   Ports:
//     clk  clock, all state on rising edge
//     rst  asynchronous reset, active-high
//     bus  cache_cpu_front_if.slave (request, handshake, lookup results)
module cache_cpu_front #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned IDX_W  = 3,
   parameter int unsigned OFF_W  = 5
) (
   input logic                 clk,
   input logic                 rst,
   cache_cpu_front_if.slave    bus
);
   localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W;
   localparam int unsigned LINES = 1 << IDX_W;

   typedef enum logic [1:0] {
      IDLE,
      SAMPLED,
      WAIT_RDY
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              capture;

   logic [ADDR_W-1:0] addr_q;
   logic              wr_rd_q;
   logic [IDX_W-1:0]  idx_q;
   logic [TAG_W-1:0]  tag_q;

   logic [TAG_W-1:0]  tag_mem [LINES];
   logic [LINES-1:0]  v_bits;
   logic [LINES-1:0]  d_bits;

   assign idx_q = addr_q[OFF_W+IDX_W-1:OFF_W];
   assign tag_q = addr_q[ADDR_W-1:OFF_W+IDX_W];

   // Next state; capture marks an edge at which a new request is taken,
   // either from IDLE or back-to-back with rdy in WAIT_RDY.
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.cs) begin
               capture   = 1'b1;
               state_nxt = SAMPLED;
            end
         end
         SAMPLED: begin
            state_nxt = WAIT_RDY;
         end
         WAIT_RDY: begin
            if (bus.rdy) begin
               if (bus.cs) begin
                  capture   = 1'b1;
                  state_nxt = SAMPLED;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         wr_rd_q <= 1'b0;
      end else if (capture) begin
         addr_q  <= bus.addr;
         wr_rd_q <= bus.wr_rd;
      end
   end

   // Updates target the request being serviced (old idx_q), even on the
   // edge where a back-to-back request replaces addr_q.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_bits <= '0;
         d_bits <= '0;
         for (int unsigned i = 0; i < LINES; i++) begin
            tag_mem[i[IDX_W-1:0]] <= '0;
         end
      end else if (state != IDLE) begin
         if (bus.valid_set) begin
            tag_mem[idx_q] <= tag_q;
            v_bits[idx_q]  <= 1'b1;
            d_bits[idx_q]  <= bus.dirty_set;
         end else if (bus.dirty_set) begin
            d_bits[idx_q]  <= 1'b1;
         end
      end
   end

   assign bus.cs_sampled_dly = (state == SAMPLED);
   assign bus.wr_rd_cpu_q    = wr_rd_q;
   assign bus.addr_q         = addr_q;
   assign bus.hit            = v_bits[idx_q] && (tag_mem[idx_q] == tag_q);
   assign bus.line_dirty     = d_bits[idx_q];
   assign bus.victim_tag     = tag_mem[idx_q];
   assign bus.busy           = (state != IDLE) && !((state == WAIT_RDY) && bus.rdy);
endmodule

// File: tb/tb_cache_cpu_front.sv
// tb_cache_cpu_front
//   Directed, table-driven bench for cache_cpu_front. Each table row holds
//   the inputs applied for one clock and the outputs expected just after
//   that edge. Hand-written sequences cover the combinational busy release
//   and an asynchronous reset in the middle of a request.
module tb_cache_cpu_front;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned OFF_W  = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   cache_cpu_front_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .OFF_W(OFF_W)) bus ();

   cache_cpu_front #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .OFF_W(OFF_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic        cs;
      logic        wr_rd;
      logic [15:0] addr;
      logic        rdy;
      logic        vs;
      logic        ds;
      logic        e_samp;
      logic        e_wrq;
      logic [15:0] e_addrq;
      logic        e_hit;
      logic        e_dirty;
      logic [7:0]  e_vic;
      logic        e_busy;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic cs, input logic wr_rd, input logic [15:0] addr,
                      input logic rdy, input logic vs, input logic ds,
                      input logic e_samp, input logic e_wrq, input logic [15:0] e_addrq,
                      input logic e_hit, input logic e_dirty, input logic [7:0] e_vic,
                      input logic e_busy);
      vec_t v;
      v.cs = cs; v.wr_rd = wr_rd; v.addr = addr; v.rdy = rdy; v.vs = vs; v.ds = ds;
      v.e_samp = e_samp; v.e_wrq = e_wrq; v.e_addrq = e_addrq; v.e_hit = e_hit;
      v.e_dirty = e_dirty; v.e_vic = e_vic; v.e_busy = e_busy;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic drive(input logic cs, input logic wr_rd, input logic [15:0] addr,
                        input logic rdy, input logic vs, input logic ds);
      bus.cs = cs; bus.wr_rd = wr_rd; bus.addr = addr;
      bus.rdy = rdy; bus.valid_set = vs; bus.dirty_set = ds;
   endtask

   task automatic check_all(input string tag, input logic e_samp, input logic e_wrq,
                            input logic [15:0] e_addrq, input logic e_hit,
                            input logic e_dirty, input logic [7:0] e_vic, input logic e_busy);
      check({tag, ".cs_sampled_dly"}, 32'(bus.cs_sampled_dly), 32'(e_samp));
      check({tag, ".wr_rd_cpu_q"},    32'(bus.wr_rd_cpu_q),    32'(e_wrq));
      check({tag, ".addr_q"},         32'(bus.addr_q),         32'(e_addrq));
      check({tag, ".hit"},            32'(bus.hit),            32'(e_hit));
      check({tag, ".line_dirty"},     32'(bus.line_dirty),     32'(e_dirty));
      check({tag, ".victim_tag"},     32'(bus.victim_tag),     32'(e_vic));
      check({tag, ".busy"},           32'(bus.busy),           32'(e_busy));
   endtask

   initial begin
      //   cs wr addr      rdy vs ds | samp wrq addr_q   hit dty vic    busy
      // read 1234 (idx 1, tag 12): cold miss, fill, complete
      add(1, 0, 16'h1234, 0, 0, 0,   1, 0, 16'h1234, 0, 0, 8'h00, 1);
      add(0, 0, 16'h0000, 0, 0, 0,   0, 0, 16'h1234, 0, 0, 8'h00, 1);
      add(0, 0, 16'h0000, 0, 1, 0,   0, 0, 16'h1234, 1, 0, 8'h12, 1);
      add(0, 0, 16'h0000, 1, 0, 0,   0, 0, 16'h1234, 1, 0, 8'h12, 0);
      // rdy in IDLE ignored
      add(0, 0, 16'h0000, 1, 0, 0,   0, 0, 16'h1234, 1, 0, 8'h12, 0);
      // re-read 1234: hit in SAMPLED
      add(1, 0, 16'h1234, 0, 0, 0,   1, 0, 16'h1234, 1, 0, 8'h12, 1);
      add(0, 0, 16'h0000, 0, 0, 0,   0, 0, 16'h1234, 1, 0, 8'h12, 1);
      add(0, 0, 16'h0000, 1, 0, 0,   0, 0, 16'h1234, 1, 0, 8'h12, 0);
      // write 1234 hit, dirty_set with rdy
      add(1, 1, 16'h1234, 0, 0, 0,   1, 1, 16'h1234, 1, 0, 8'h12, 1);
      add(0, 0, 16'h0000, 0, 0, 0,   0, 1, 16'h1234, 1, 0, 8'h12, 1);
      add(0, 0, 16'h0000, 1, 0, 1,   0, 1, 16'h1234, 1, 1, 8'h12, 0);
      // read AB34: conflict miss on dirty line, victim tag 12; then fill
      add(1, 0, 16'hAB34, 0, 0, 0,   1, 0, 16'hAB34, 0, 1, 8'h12, 1);
      add(0, 0, 16'h0000, 0, 0, 0,   0, 0, 16'hAB34, 0, 1, 8'h12, 1);
      add(0, 0, 16'h0000, 0, 1, 0,   0, 0, 16'hAB34, 1, 0, 8'hAB, 1);
      add(0, 0, 16'h0000, 1, 0, 0,   0, 0, 16'hAB34, 1, 0, 8'hAB, 0);
      // read 1234 misses now; cs held with 0040 while busy is ignored
      add(1, 0, 16'h1234, 0, 0, 0,   1, 0, 16'h1234, 0, 0, 8'hAB, 1);
      add(1, 0, 16'h0040, 0, 0, 0,   0, 0, 16'h1234, 0, 0, 8'hAB, 1);
      add(1, 1, 16'h0040, 0, 0, 0,   0, 0, 16'h1234, 0, 0, 8'hAB, 1);
      // rdy and cs together: back-to-back capture of 0060 (idx 3)
      add(1, 0, 16'h0060, 1, 0, 0,   1, 0, 16'h0060, 0, 0, 8'h00, 1);
      add(0, 0, 16'h0000, 0, 0, 0,   0, 0, 16'h0060, 0, 0, 8'h00, 1);
      // valid_set and dirty_set together: write-allocate
      add(0, 0, 16'h0000, 0, 1, 1,   0, 0, 16'h0060, 1, 1, 8'h00, 1);
      add(0, 0, 16'h0000, 1, 0, 0,   0, 0, 16'h0060, 1, 1, 8'h00, 0);
      add(1, 0, 16'h0060, 0, 0, 0,   1, 0, 16'h0060, 1, 1, 8'h00, 1);
      add(0, 0, 16'h0000, 0, 0, 0,   0, 0, 16'h0060, 1, 1, 8'h00, 1);

      drive(0, 0, 16'h0000, 0, 0, 0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 0, 0, 16'h0000, 0, 0, 8'h00, 0);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].cs, vecs[i].wr_rd, vecs[i].addr, vecs[i].rdy, vecs[i].vs, vecs[i].ds);
         @(posedge clk);
         #1;
         check_all($sformatf("vec%0d", i), vecs[i].e_samp, vecs[i].e_wrq, vecs[i].e_addrq,
                   vecs[i].e_hit, vecs[i].e_dirty, vecs[i].e_vic, vecs[i].e_busy);
      end

      // DUT is in WAIT_RDY for 0060: busy drops combinationally with rdy
      drive(0, 0, 16'h0000, 1, 0, 0);
      #1;
      check("busy_rdy_comb", 32'(bus.busy), 32'd0);
      drive(0, 0, 16'h0000, 0, 0, 0);
      #1;
      check("busy_rdy_low", 32'(bus.busy), 32'd1);

      // asynchronous reset in WAIT_RDY, between clock edges
      #1;
      rst = 1'b1;
      #1;
      check_all("async_rst", 0, 0, 16'h0000, 0, 0, 8'h00, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_held_samp", 32'(bus.cs_sampled_dly), 32'd0);

      // previously filled line 0060 must miss after reset
      drive(1, 0, 16'h0060, 0, 0, 0);
      @(posedge clk);
      #1;
      check_all("post_rst", 1, 0, 16'h0060, 0, 0, 8'h00, 1);
      drive(0, 0, 16'h0000, 0, 0, 0);
      @(posedge clk);
      #1;
      check("post_rst_pulse_end", 32'(bus.cs_sampled_dly), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
